gsensor_poll_ctrl: RTL and testbench

- Sequencer for the ADXL345 G-sensor on the MAX10 board. It sits between the byte-level SPI master, which drives GSENSOR_CS_N, SCLK, SDI and SDO, and the accel datapath consumer of data_x, data_y and data_z.
- After reset it writes the sensor's init registers. It then polls X/Y/Z on a fixed-period timer and publishes 16-bit samples with a one-cycle valid strobe.
- It is the only master of the SPI engine: it detects overrun and recovers from a hung SPI master by timeout.

---
 rtl/gsensor_poll_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_gsensor_poll_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsensor_poll_ctrl.sv
// ADXL345 sequencer: writes the init registers, then polls X/Y/Z on a fixed-period tick
// through a byte-level SPI master and publishes 16-bit samples with a one-cycle strobe.
//
// state     | meaning
// IDLE      | parked until enable; re-inits if init_done is low
// INIT_REQ  | idle gap, then raise the next init write request
// INIT_WAIT | init write in flight, waiting for spi_done or timeout
// WAIT_TICK | initialised, waiting for the sample tick
// RD_REQ    | idle gap, then raise the next data byte read
// RD_WAIT   | data read in flight, waiting for spi_done or timeout
// PUBLISH   | load data_x/y/z from the shadows and strobe data_valid
module gsensor_poll_ctrl #(
  parameter int unsigned SAMPLE_DIV      = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B,
  parameter logic [7:0]  BW_RATE_VAL     = 8'h0A,
  parameter logic [7:0]  POWER_CTL_VAL   = 8'h08
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        spi_req,
  output logic        spi_rw,
  output logic [5:0]  spi_addr,
  output logic [7:0]  spi_wdata,
  input  logic        spi_done,
  input  logic [7:0]  spi_rdata,
  output logic [15:0] data_x,
  output logic [15:0] data_y,
  output logic [15:0] data_z,
  output logic        data_valid,
  output logic        init_done,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]        RD_BASE   = 6'h32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_REQ,
    S_INIT_WAIT,
    S_WAIT_TICK,
    S_RD_REQ,
    S_RD_WAIT,
    S_PUBLISH
  } state_t;

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [TO_W-1:0]   wait_cnt;
  logic [2:0]        idx;
  logic [7:0]        shadow [0:5];
  logic              tick_run;
  logic              tick;
  logic              in_burst;

  function automatic logic [5:0] init_addr(input logic [2:0] i);
    case (i)
      3'd0:    init_addr = 6'h31;
      3'd1:    init_addr = 6'h2C;
      default: init_addr = 6'h2D;
    endcase
  endfunction

  function automatic logic [7:0] init_data(input logic [2:0] i);
    case (i)
      3'd0:    init_data = DATA_FORMAT_VAL;
      3'd1:    init_data = BW_RATE_VAL;
      default: init_data = POWER_CTL_VAL;
    endcase
  endfunction

  assign tick_run = init_done & enable;
  assign tick     = tick_run & (tick_cnt == TICK_LAST);
  assign in_burst = (state == S_RD_REQ) | (state == S_RD_WAIT) | (state == S_PUBLISH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!tick_run || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // The request is raised on the edge leaving a *_REQ state (or WAIT_TICK on a tick),
  // so every cycle with spi_req high is spent in a *_WAIT state and is timed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      idx         <= '0;
      spi_req     <= 1'b0;
      spi_rw      <= 1'b0;
      spi_addr    <= '0;
      spi_wdata   <= '0;
      data_x      <= '0;
      data_y      <= '0;
      data_z      <= '0;
      data_valid  <= 1'b0;
      init_done   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 6; i++) shadow[i] <= '0;
    end else begin
      data_valid <= 1'b0;
      if (tick && in_burst) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (enable) begin
            if (init_done) begin
              state <= S_WAIT_TICK;
            end else begin
              idx   <= '0;
              state <= S_INIT_REQ;
            end
          end
        end

        S_INIT_REQ: begin
          spi_req   <= 1'b1;
          spi_rw    <= 1'b0;
          spi_addr  <= init_addr(idx);
          spi_wdata <= init_data(idx);
          wait_cnt  <= TO_LOAD;
          state     <= S_INIT_WAIT;
        end

        S_INIT_WAIT: begin
          if (spi_done) begin
            spi_req <= 1'b0;
            if (idx == 3'd2) begin
              init_done   <= 1'b1;
              timeout_err <= 1'b0;
              state       <= S_WAIT_TICK;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_INIT_REQ;
            end
          end else if (wait_cnt == '0) begin
            spi_req     <= 1'b0;
            timeout_err <= 1'b1;
            init_done   <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - TO_W'(1);
          end
        end

        S_WAIT_TICK: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (tick) begin
            idx       <= '0;
            spi_req   <= 1'b1;
            spi_rw    <= 1'b1;
            spi_addr  <= RD_BASE;
            spi_wdata <= '0;
            wait_cnt  <= TO_LOAD;
            state     <= S_RD_WAIT;
          end
        end

        S_RD_REQ: begin
          spi_req   <= 1'b1;
          spi_rw    <= 1'b1;
          spi_addr  <= RD_BASE + {3'b000, idx};
          spi_wdata <= '0;
          wait_cnt  <= TO_LOAD;
          state     <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (spi_done) begin
            spi_req     <= 1'b0;
            shadow[idx] <= spi_rdata;
            if (idx == 3'd5) begin
              state <= S_PUBLISH;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_RD_REQ;
            end
          end else if (wait_cnt == '0) begin
            // Partial shadows are simply never published; the next burst overwrites them.
            spi_req     <= 1'b0;
            timeout_err <= 1'b1;
            init_done   <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - TO_W'(1);
          end
        end

        S_PUBLISH: begin
          data_x     <= {shadow[1], shadow[0]};
          data_y     <= {shadow[3], shadow[2]};
          data_z     <= {shadow[5], shadow[4]};
          data_valid <= 1'b1;
          state      <= S_WAIT_TICK;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsensor_poll_ctrl.sv
// Bench for gsensor_poll_ctrl: behavioural ADXL345/SPI responder with a register array,
// table-driven poll bursts plus hand-written overrun, disable, timeout and reset sequences.
module tb_gsensor_poll_ctrl;

  localparam int DIV = 200;
  localparam int TO  = 50;
  localparam int NV  = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        spi_req;
  logic        spi_rw;
  logic [5:0]  spi_addr;
  logic [7:0]  spi_wdata;
  logic        spi_done;
  logic [7:0]  spi_rdata;
  logic [15:0] data_x;
  logic [15:0] data_y;
  logic [15:0] data_z;
  logic        data_valid;
  logic        init_done;
  logic        overrun;
  logic        timeout_err;

  gsensor_poll_ctrl #(
    .SAMPLE_DIV     (DIV),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .spi_req     (spi_req),
    .spi_rw      (spi_rw),
    .spi_addr    (spi_addr),
    .spi_wdata   (spi_wdata),
    .spi_done    (spi_done),
    .spi_rdata   (spi_rdata),
    .data_x      (data_x),
    .data_y      (data_y),
    .data_z      (data_z),
    .data_valid  (data_valid),
    .init_done   (init_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [5:0] addr;
    logic [7:0] wdata;
  } txn_t;

  typedef struct {
    int          lat;
    logic [47:0] bytes;
    logic [15:0] ex;
    logic [15:0] ey;
    logic [15:0] ez;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_valid = 0;
  int   n_burst = 0;
  int   last_done_cyc = 0;
  int   done37_cyc = 0;
  int   init_rise_cyc = 0;
  int   burst_cyc_last = 0;
  int   burst_cyc_prev = 0;
  int   last_len = 0;
  int   req_cycles = 0;
  int   ack_lat = 20;
  bit   active = 0;
  bit   done_given = 0;
  bit   hang = 0;
  bit   hang_arm = 0;
  bit   prev_dv = 0;
  bit   prev_init = 0;
  logic [5:0]  hang_addr = 6'h35;
  logic [7:0]  mem [0:63];
  logic [15:0] vx, vy, vz;
  txn_t cur;
  txn_t txq [$];
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [47:0] v, input int k);
    return v[8*k +: 8];
  endfunction

  // Little-endian pair: low address is the low byte.
  function automatic logic [15:0] word_of(input logic [47:0] v, input int p);
    int lo, hi;
    lo = int'(byte_of(v, 2*p));
    hi = int'(byte_of(v, 2*p + 1));
    return 16'(hi * 256 + lo);
  endfunction

  function automatic logic [13:0] init_exp(input int k);
    case (k)
      0:       return {6'h31, 8'h0B};
      1:       return {6'h2C, 8'h0A};
      default: return {6'h2D, 8'h08};
    endcase
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), $urandom};
  endfunction

  task automatic load_mem(input logic [47:0] v);
    for (int k = 0; k < 6; k++) mem[50 + k] = byte_of(v, k);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int maxc, input string name);
    int snap;
    snap = n_valid;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      #2;
      if (n_valid != snap) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no data_valid within %0d cycles", name, maxc);
  endtask

  // which: 0 = init_done high, 1 = timeout_err high, otherwise a new read burst started
  task automatic wait_cond(input int which, input int maxc, input string name);
    int snap;
    snap = n_burst;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      #2;
      case (which)
        0:       if (init_done === 1'b1) return;
        1:       if (timeout_err === 1'b1) return;
        default: if (n_burst != snap) return;
      endcase
    end
    checks++;
    errors++;
    $display("FAIL %s: condition not reached within %0d cycles", name, maxc);
  endtask

  task automatic check_init(input int base);
    logic [13:0] e;
    for (int k = 0; k < 3; k++) begin
      if (base + k < txq.size()) begin
        e = init_exp(k);
        chk("init_rw", txq[base+k].rw, 0);
        chk("init_addr", txq[base+k].addr, e[13:8]);
        chk("init_wdata", txq[base+k].wdata, e[7:0]);
      end else begin
        checks++;
        errors++;
        $display("FAIL init_missing: write %0d absent, got %0d txns", k, txq.size() - base);
      end
    end
  endtask

  task automatic check_reads(input int base);
    chk("rd_count", txq.size() - base, 6);
    for (int k = 0; k < 6; k++) begin
      if (base + k < txq.size()) begin
        chk("rd_rw", txq[base+k].rw, 1);
        chk("rd_addr", txq[base+k].addr, 50 + k);
        chk("rd_wdata", txq[base+k].wdata, 0);
      end
    end
  endtask

  // SPI responder and output monitors, sampled 1 time unit after each rising edge.
  initial begin
    spi_done  = 1'b0;
    spi_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      spi_done = 1'b0;

      if (data_valid === 1'b1) begin
        chk("dv_pulse_width", prev_dv, 0);
        chk("dv_latency", cyc - done37_cyc, 2);
        n_valid++;
        vx = data_x;
        vy = data_y;
        vz = data_z;
      end
      prev_dv = (data_valid === 1'b1);

      if (init_done === 1'b1 && !prev_init) begin
        chk("init_done_latency", cyc - last_done_cyc, 1);
        init_rise_cyc = cyc;
      end
      prev_init = (init_done === 1'b1);

      if (done_given) begin
        chk("req_low_after_done", spi_req, 0);
        done_given = 0;
        if (active) last_len = req_cycles;
        active = 0;
      end else if (spi_req === 1'b1) begin
        if (!active) begin
          active     = 1;
          req_cycles = 0;
          cur.rw     = spi_rw;
          cur.addr   = spi_addr;
          cur.wdata  = spi_wdata;
          txq.push_back(cur);
          if (spi_rw && spi_addr == 6'h32) begin
            n_burst++;
            burst_cyc_prev = burst_cyc_last;
            burst_cyc_last = cyc;
          end
          hang = hang_arm && spi_rw && (spi_addr == hang_addr);
          if (hang) hang_arm = 0;
        end
        req_cycles++;
        if (!hang && req_cycles == ack_lat) begin
          chk("txn_stable", {spi_rw, spi_addr, spi_wdata}, cur);
          spi_done  = 1'b1;
          spi_rdata = spi_rw ? mem[spi_addr] : 8'h00;
          if (!spi_rw) mem[spi_addr] = spi_wdata;
          done_given    = 1;
          last_done_cyc = cyc;
          if (spi_rw && spi_addr == 6'h37) done37_cyc = cyc;
        end
      end else begin
        if (active) last_len = req_cycles;
        active = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nv, hb;
    logic [47:0] v;
    logic [15:0] sx, sy, sz;

    reset_n = 1'b0;
    enable  = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    vecs[0] = '{lat: 20, bytes: 48'h07_89_04_56_01_23, ex: 16'h0123, ey: 16'h0456, ez: 16'h0789};
    vecs[1] = '{lat: 1,  bytes: 48'h7F_FF_80_00_FF_FF, ex: 16'hFFFF, ey: 16'h8000, ez: 16'h7FFF};
    for (int i = 2; i < NV; i++) begin
      vecs[i].lat   = int'($urandom_range(2, 25));
      vecs[i].bytes = rand48();
      vecs[i].ex    = word_of(vecs[i].bytes, 0);
      vecs[i].ey    = word_of(vecs[i].bytes, 1);
      vecs[i].ez    = word_of(vecs[i].bytes, 2);
    end

    wait_cycles(3);
    chk("rst_ctl", {spi_req, spi_rw, spi_addr, spi_wdata, data_valid, init_done, overrun, timeout_err}, 0);
    chk("rst_data", {data_x, data_y, data_z}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(5);
    chk("idle_no_req", txq.size(), 0);

    // Init sequence
    ack_lat = 20;
    base = txq.size();
    enable = 1'b1;
    wait_cond(0, 400, "init_wait");
    chk("init_txn_count", txq.size() - base, 3);
    check_init(base);
    chk("terr_after_init", timeout_err, 0);

    // Table-driven poll bursts
    for (int i = 0; i < NV; i++) begin
      ack_lat = vecs[i].lat;
      load_mem(vecs[i].bytes);
      base = txq.size();
      wait_valid(700, "poll_valid");
      chk("poll_x", vx, vecs[i].ex);
      chk("poll_y", vy, vecs[i].ey);
      chk("poll_z", vz, vecs[i].ez);
      check_reads(base);
      if (i == 0) chk("first_tick_latency", burst_cyc_last - init_rise_cyc, DIV);
      else        chk("tick_period", burst_cyc_last - burst_cyc_prev, DIV);
    end
    wait_cycles(20);
    chk("data_hold", {data_x, data_y, data_z}, {vecs[NV-1].ex, vecs[NV-1].ey, vecs[NV-1].ez});
    chk("no_overrun_yet", overrun, 0);

    // Overrun: burst longer than the sample period
    ack_lat = 40;
    for (int r = 0; r < 2; r++) begin
      v = rand48();
      load_mem(v);
      wait_valid(1200, "ovr_valid");
      chk("ovr_x", vx, word_of(v, 0));
      chk("ovr_y", vy, word_of(v, 1));
      chk("ovr_z", vz, word_of(v, 2));
    end
    chk("overrun_set", overrun, 1);
    ack_lat = 10;
    v = rand48();
    load_mem(v);
    wait_valid(1200, "post_ovr_valid");
    chk("post_ovr_x", vx, word_of(v, 0));
    chk("overrun_sticky", overrun, 1);

    // Disable during a burst, then re-enable
    ack_lat = 12;
    v = rand48();
    load_mem(v);
    wait_cond(3, 600, "dis_burst_start");
    enable = 1'b0;
    wait_valid(300, "dis_valid");
    chk("dis_x", vx, word_of(v, 0));
    chk("dis_z", vz, word_of(v, 2));
    base = txq.size();
    nv = n_valid;
    wait_cycles(600);
    chk("dis_no_req", txq.size() - base, 0);
    chk("dis_no_valid", n_valid - nv, 0);
    chk("dis_init_kept", init_done, 1);
    v = rand48();
    load_mem(v);
    base = txq.size();
    enable = 1'b1;
    wait_valid(500, "reen_valid");
    check_reads(base);
    chk("reen_y", vy, word_of(v, 1));

    // Timeout on the 4th read
    ack_lat = 10;
    load_mem(rand48());
    hang_addr = 6'h35;
    hang_arm = 1;
    sx = data_x;
    sy = data_y;
    sz = data_z;
    nv = n_valid;
    base = txq.size();
    wait_cond(1, 800, "terr_wait");
    chk("to_req_len", last_len, TO);
    chk("to_req_low", spi_req, 0);
    chk("to_init_done", init_done, 0);
    chk("to_data_kept", {data_x, data_y, data_z}, {sx, sy, sz});
    chk("to_no_valid", n_valid - nv, 0);
    chk("to_txn_count", txq.size() - base, 4);
    hb = txq.size();
    wait_cond(0, 400, "reinit_wait");
    chk("reinit_count", txq.size() - hb, 3);
    check_init(hb);
    chk("terr_cleared", timeout_err, 0);

    // Asynchronous reset in the middle of a read
    wait_cond(3, 600, "rst_burst_start");
    wait_cycles(2);
    chk("rst_pre_req", spi_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ctl", {spi_req, spi_rw, spi_addr, spi_wdata, data_valid, init_done, overrun, timeout_err}, 0);
    chk("arst_data", {data_x, data_y, data_z}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    base = txq.size();
    wait_cond(0, 400, "rst_reinit");
    chk("rst_reinit_count", txq.size() - base, 3);
    check_init(base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
